id_stage: RTL and testbench

//  Decode/register-read stage directly upstream of the ALU. Accepts one 32-bit

---
 rtl/id_stage_pkg.sv | 77 +++++++
 rtl/id_stage_reg_file.sv | 32 +++
 rtl/id_stage.sv | 130 +++++++++++++
 tb/tb_id_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the id_stage slice: widths, MIPS opcodes,
// instruction field positions and the decoded-instruction record.
package id_stage_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int NREGS   = 1 << RADDR_W;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   typedef logic [RADDR_W-1:0] raddr_t;
   typedef logic [XLEN-1:0]    xword_t;

   typedef struct packed {
      logic [5:0] opcode;
      logic [5:0] funct;
      raddr_t     rs;
      raddr_t     rt;
      raddr_t     dest;
      logic       use_rs;
      logic       use_rt;
      logic       use_imm;
      xword_t     imm;
   } dec_t;

   typedef struct packed {
      logic [5:0] opcode;
      logic [5:0] funct;
      xword_t     bus_a;
      xword_t     bus_b;
      raddr_t     dest;
   } ex_reg_t;

   function automatic xword_t sext16(input logic [15:0] v);
      return {{(XLEN-16){v[15]}}, v};
   endfunction

   // Unknown opcodes decode to an ALU NOP: no sources, no destination.
   function automatic dec_t decode(input logic [31:0] ins);
      dec_t d;
      d        = '0;
      d.opcode = ins[OP_MSB:OP_LSB];
      d.funct  = ins[FUNCT_MSB:FUNCT_LSB];
      d.rs     = ins[RS_MSB:RS_LSB];
      d.rt     = ins[RT_MSB:RT_LSB];
      case (d.opcode)
         OP_RTYPE: begin
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
            d.dest   = ins[RD_MSB:RD_LSB];
         end
         OP_ADDI: begin
            d.use_rs  = 1'b1;
            d.use_imm = 1'b1;
            d.dest    = ins[RT_MSB:RT_LSB];
            d.imm     = sext16(ins[IMM_MSB:IMM_LSB]);
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32-entry register file: two combinational read ports, one write port on posedge.
// r0 reads as zero and ignores writes; synchronous reset clears every entry.
module id_stage_reg_file
   import id_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [RADDR_W-1:0] raddr_a,
   output logic [XLEN-1:0]    rdata_a,
   input  logic [RADDR_W-1:0] raddr_b,
   output logic [XLEN-1:0]    rdata_b,
   input  logic               we,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]    wdata
);

   xword_t regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Decode/register-read stage feeding the ALU; 1-cycle issue latency, holds while ex_ready=0,
// stalls on scoreboard RAW/WAW hazards. WB_BYPASS_EN forwards writeback into the operand read.
module id_stage
   import id_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [31:0]        instr,
   output logic               instr_ready,
   output logic               ex_valid,
   input  logic               ex_ready,
   output logic [5:0]         opcode,
   output logic [5:0]         funct,
   output logic [XLEN-1:0]    busA,
   output logic [XLEN-1:0]    busB,
   output logic [RADDR_W-1:0] dest,
   input  logic               wb_en,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]    wb_data
);

   dec_t              dec;
   xword_t            rf_a;
   xword_t            rf_b;
   xword_t            opa;
   xword_t            opb;
   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  pend_eff;
   logic [NREGS-1:0]  pending_nxt;
   logic              wb_live;
   logic              stall;
   logic              issue;
   logic              ex_vld_q;
   ex_reg_t           ex_q;
   ex_reg_t           ex_nxt;

   assign dec     = decode(instr);
   assign wb_live = wb_en && (wb_addr != '0);

   id_stage_reg_file u_rf (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (dec.rs),
      .rdata_a (rf_a),
      .raddr_b (dec.rt),
      .rdata_b (rf_b),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

`ifdef WB_BYPASS_EN
   // A retiring writeback both supplies the operand and releases its scoreboard bit.
   assign opa = (wb_live && (wb_addr == dec.rs)) ? wb_data : rf_a;
   assign opb = (wb_live && (wb_addr == dec.rt)) ? wb_data : rf_b;

   always_comb begin
      pend_eff = pending;
      if (wb_live) begin
         pend_eff[wb_addr] = 1'b0;
      end
   end
`else
   assign opa      = rf_a;
   assign opb      = rf_b;
   assign pend_eff = pending;
`endif

   assign stall = (dec.use_rs && pend_eff[dec.rs])
                | (dec.use_rt && pend_eff[dec.rt])
                | ((dec.dest != '0) && pend_eff[dec.dest]);

   assign instr_ready = !rst && !stall && (!ex_vld_q || ex_ready);
   assign issue       = instr_valid && instr_ready;

   always_comb begin
      ex_nxt        = '0;
      ex_nxt.opcode = dec.opcode;
      ex_nxt.funct  = dec.funct;
      ex_nxt.dest   = dec.dest;
      ex_nxt.bus_a  = dec.use_rs ? opa : '0;
      if (dec.use_imm) begin
         ex_nxt.bus_b = dec.imm;
      end else if (dec.use_rt) begin
         ex_nxt.bus_b = opb;
      end
   end

   // Set after clear so an issuing destination survives a same-cycle writeback.
   always_comb begin
      pending_nxt = pending;
      if (wb_live) begin
         pending_nxt[wb_addr] = 1'b0;
      end
      if (issue && (dec.dest != '0)) begin
         pending_nxt[dec.dest] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
         pending  <= '0;
      end else begin
         pending <= pending_nxt;
         if (issue) begin
            ex_vld_q <= 1'b1;
            ex_q     <= ex_nxt;
         end else if (ex_ready) begin
            ex_vld_q <= 1'b0;
         end
      end
   end

   assign ex_valid = ex_vld_q;
   assign opcode   = ex_q.opcode;
   assign funct    = ex_q.funct;
   assign busA     = ex_q.bus_a;
   assign busB     = ex_q.bus_b;
   assign dest     = ex_q.dest;

   a_hold_stable: assert property (@(posedge clk)
      (!rst && ex_vld_q && !ex_ready) |=> (rst || (ex_vld_q && $stable(ex_q))));

   a_r0_never_pending: assert property (@(posedge clk) !pending[0]);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed hazard/backpressure/reset sequences, then random traffic
// checked cycle-by-cycle against an architectural model of registers and pending writes.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        ex_valid;
   logic        ex_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] busA;
   logic [31:0] busB;
   logic [4:0]  dest;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   id_stage dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .opcode      (opcode),
      .funct       (funct),
      .busA        (busA),
      .busB        (busB),
      .dest        (dest),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Architectural model: register values, outstanding writes, and the ALU-facing slot.
   logic [31:0] m_reg  [32];
   bit          m_pend [32];
   bit          m_vld;
   logic [5:0]  m_op;
   logic [5:0]  m_fn;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [4:0]  m_dest;
   bit          e_ready;
   logic [31:0] e_a;
   logic [31:0] e_b;
   logic [4:0]  e_dest;
   bit          last_ready;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] read_src(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_en && (wb_addr == r)) return wb_data;
      return m_reg[r];
   endfunction

   function automatic bit busy(input logic [4:0] r);
      return (r != 5'd0) && m_pend[r] && !(BYP && wb_en && (wb_addr == r));
   endfunction

   task automatic model_comb();
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      bit         hazard;
      op     = instr[31:26];
      rs     = instr[25:21];
      rt     = instr[20:16];
      e_a    = 32'd0;
      e_b    = 32'd0;
      e_dest = 5'd0;
      hazard = 1'b0;
      if (op == 6'd0) begin
         e_a    = read_src(rs);
         e_b    = read_src(rt);
         e_dest = instr[15:11];
         hazard = busy(rs) || busy(rt) || busy(e_dest);
      end else if (op == 6'd8) begin
         e_a    = read_src(rs);
         e_b    = {{16{instr[15]}}, instr[15:0]};
         e_dest = instr[20:16];
         hazard = busy(rs) || busy(e_dest);
      end
      e_ready = !rst && !hazard && (!m_vld || ex_ready);
   endtask

   // One clock: inputs already driven at the preceding negedge.
   task automatic step();
      bit issue;
      #1;
      model_comb();
      last_ready = instr_ready;
      check("instr_ready", 32'(instr_ready), 32'(e_ready));
      issue = instr_valid && e_ready;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
         end
         m_vld = 1'b0; m_op = 6'd0; m_fn = 6'd0; m_a = 32'd0; m_b = 32'd0; m_dest = 5'd0;
      end else begin
         if (wb_en && (wb_addr != 5'd0)) begin
            m_reg[wb_addr]  = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (issue) begin
            m_vld  = 1'b1;
            m_op   = instr[31:26];
            m_fn   = instr[5:0];
            m_a    = e_a;
            m_b    = e_b;
            m_dest = e_dest;
            if (e_dest != 5'd0) m_pend[e_dest] = 1'b1;
         end else if (ex_ready) begin
            m_vld = 1'b0;
         end
      end
      @(negedge clk);
      check("ex_valid", 32'(ex_valid), 32'(m_vld));
      if (m_vld) begin
         check("opcode", 32'(opcode), 32'(m_op));
         check("funct", 32'(funct), 32'(m_fn));
         check("busA", busA, m_a);
         check("busB", busB, m_b);
         check("dest", 32'(dest), 32'(m_dest));
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int unsigned k;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  fn;
      k  = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      fn = 6'($urandom_range(32, 42));
      if (k < 4) return {6'd0, rs, rt, rd, 5'd0, fn};
      if (k < 8) return {6'd8, rs, rt, 16'($urandom)};
      op = 6'($urandom_range(1, 63));
      if (op == 6'd8) op = 6'd9;
      return {op, 26'($urandom)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; ex_ready = 1'b0;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      m_vld = 1'b0; m_op = 6'd0; m_fn = 6'd0; m_a = 32'd0; m_b = 32'd0; m_dest = 5'd0;
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = 32'd0; m_pend[i] = 1'b0;
      end

      step(); step();
      rst = 1'b0;

      // ADDI r1,r0,-5
      instr = 32'h2001FFFB; instr_valid = 1'b1; ex_ready = 1'b1;
      step();
      check("addi_rdy", 32'(last_ready), 32'd1);
      check("addi_vld", 32'(ex_valid), 32'd1);
      check("addi_busA", busA, 32'd0);
      check("addi_busB", busB, 32'hFFFFFFFB);
      check("addi_dest", 32'(dest), 32'd1);
      check("addi_op", 32'(opcode), 32'h08);

      // Backpressure: ALU holds three cycles, then releases
      instr = 32'h20020003; ex_ready = 1'b0;
      repeat (3) begin
         step();
         check("bp_rdy", 32'(last_ready), 32'd0);
         check("bp_busB", busB, 32'hFFFFFFFB);
         check("bp_dest", 32'(dest), 32'd1);
      end
      ex_ready = 1'b1;
      step();
      check("bp_rel_rdy", 32'(last_ready), 32'd1);
      check("bp_rel_busB", busB, 32'd3);
      check("bp_rel_dest", 32'(dest), 32'd2);

      // Reset while holding
      ex_ready = 1'b0; rst = 1'b1;
      step(); step();
      check("rst_rdy", 32'(last_ready), 32'd0);
      check("rst_vld", 32'(ex_valid), 32'd0);
      check("rst_op", 32'(opcode), 32'd0);
      check("rst_fn", 32'(funct), 32'd0);
      check("rst_busA", busA, 32'd0);
      check("rst_busB", busB, 32'd0);
      check("rst_dest", 32'(dest), 32'd0);
      rst = 1'b0; instr = 32'd0; instr_valid = 1'b0;
      step();
      check("post_rst_rdy", 32'(last_ready), 32'd1);

      // RAW: ADDI r1,r0,5 then ADD r2,r1,r1
      ex_ready = 1'b1; instr = 32'h20010005; instr_valid = 1'b1;
      step();
      instr = 32'h00211020;
      repeat (2) begin
         step();
         check("raw_stall", 32'(last_ready), 32'd0);
      end
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
      step();
      check("raw_wb_rdy", 32'(last_ready), 32'(BYP));
      check("raw_wb_vld", 32'(ex_valid), 32'(BYP));
      if (ex_valid) begin
         check("raw_busA", busA, 32'd7); check("raw_busB", busB, 32'd7);
      end
      wb_en = 1'b0;
      step();
      check("raw_next_vld", 32'(ex_valid), 32'(!BYP));
      if (ex_valid) begin
         check("raw_busA", busA, 32'd7); check("raw_busB", busB, 32'd7);
      end
      instr_valid = 1'b0;

      // r0 write ignored
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000DEAD;
      step();
      wb_en = 1'b0; instr = 32'h00001820; instr_valid = 1'b1;
      step();
      check("r0_rdy", 32'(last_ready), 32'd1);
      check("r0_busA", busA, 32'd0);
      check("r0_busB", busB, 32'd0);
      check("r0_dest", 32'(dest), 32'd3);

      // WAW with same-cycle writeback: r4 must remain pending
      instr = 32'h20040001;
      step();
      instr = 32'h20040002; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h11;
      step();
      check("waw_wb_rdy", 32'(last_ready), 32'(BYP));
      wb_en = 1'b0;
      step();
      check("waw_second_rdy", 32'(last_ready), 32'(!BYP));
      instr = 32'h00842820;
      step();
      check("waw_pend4", 32'(last_ready), 32'd0);

      instr_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 199) == 0);
         instr_valid = ($urandom_range(0, 9) < 8);
         instr       = rand_instr();
         ex_ready    = ($urandom_range(0, 9) < 7);
         wb_en       = ($urandom_range(0, 9) < 4);
         wb_addr     = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
